reg_file_param: RTL

//   Parametrised register file for the decode stage: DEPTH entries of WIDTH bits,
//   NUM_READ registered read ports and one write port. Replaces the fixed
//   2-read / 32x32 file and adds reset, a configurable port count and a

---
 rtl/reg_file_pkg.sv | 19 +
 rtl/reg_file_read_port.sv | 68 ++++++
 rtl/reg_file_param.sv | 62 ++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants, read-source encoding and zero-register helper for the decode-stage register file.
package reg_file_pkg;

  localparam int          REG_ADDR_W  = 5;
  localparam int          REG_WIDTH   = 32;
  localparam logic [31:0] REG_ZERO_ID = 32'd0;

  typedef enum logic [1:0] {
    SRC_ENTRY  = 2'd0,
    SRC_ZERO   = 2'd1,
    SRC_BYPASS = 2'd2
  } rd_src_e;

  // True when the index addresses the hardwired-zero entry and that entry is enabled.
  function automatic logic zero_hit(input int zero_reg, input logic [31:0] id);
    return (zero_reg != 0) && (id == REG_ZERO_ID);
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One registered read port: index mux, zero-register masking, optional write-first
// forwarding (REG_FILE_BYPASS_EN) and the output register.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = REG_WIDTH,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
`ifdef REG_FILE_BYPASS_EN
  input  logic              i_write_en,
  input  logic [ADDR_W-1:0] i_write_id,
  input  logic [WIDTH-1:0]  i_write_val,
`endif
  input  logic [ADDR_W-1:0] i_read_id,
  input  logic [WIDTH-1:0]  i_mem [DEPTH],
  output logic [WIDTH-1:0]  o_read_val
);

  rd_src_e          w_src;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] r_read_val;
  logic             w_zero_hit;

  assign w_zero_hit = zero_hit(ZERO_REG, 32'(i_read_id));

  // Zero masking wins over forwarding, so a dropped zero-entry write never leaks out.
  always_comb begin
    w_src = SRC_ENTRY;
    if (w_zero_hit) begin
      w_src = SRC_ZERO;
`ifdef REG_FILE_BYPASS_EN
    end else if (i_write_en && (i_write_id == i_read_id)) begin
      w_src = SRC_BYPASS;
`endif
    end else begin
      w_src = SRC_ENTRY;
    end
  end

  // Select the value to be captured at the next edge.
  always_comb begin
    w_next = '0;
    case (w_src)
      SRC_ZERO:   w_next = '0;
`ifdef REG_FILE_BYPASS_EN
      SRC_BYPASS: w_next = i_write_val;
`endif
      SRC_ENTRY:  w_next = i_mem[i_read_id];
      default:    w_next = '0;
    endcase
  end

  // Output register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_read_val <= '0;
    end else begin
      r_read_val <= w_next;
    end
  end

  assign o_read_val = r_read_val;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: DEPTH x WIDTH storage, one write port, NUM_READ registered
// read ports. Define REG_FILE_BYPASS_EN for write-first same-edge forwarding.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = REG_WIDTH,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_READ*ADDR_W-1:0] read_id,
  input  logic                       write_en,
  input  logic [ADDR_W-1:0]          write_id,
  input  logic [WIDTH-1:0]           write_val,
  output logic [NUM_READ*WIDTH-1:0]  read_val
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (ADDR_W != $clog2(DEPTH)) ||
      (NUM_READ < 1) || (NUM_READ > 4) || ((ZERO_REG != 0) && (ZERO_REG != 1))) begin : g_param_check
    $error("reg_file_param: illegal parameter combination");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr_ok;

  assign w_wr_ok = write_en && !zero_hit(ZERO_REG, 32'(write_id));

  // Entry storage; writes to the hardwired-zero entry are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[write_id] <= write_val;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    reg_file_read_port #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .i_clk      (clock),
      .i_rst      (reset),
`ifdef REG_FILE_BYPASS_EN
      .i_write_en (write_en),
      .i_write_id (write_id),
      .i_write_val(write_val),
`endif
      .i_read_id  (read_id[p*ADDR_W +: ADDR_W]),
      .i_mem      (r_mem),
      .o_read_val (read_val[p*WIDTH +: WIDTH])
    );
  end

endmodule
